// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates loads and committed stores onto one memory port through a
// one-entry request register, tracking in-flight requests in an in-order FIFO.
module dmem_arbiter #(
    parameter int TAG_W    = 6,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_valid,
    input  logic             st_urgent,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [31:0]      ld_addr,
    input  logic [1:0]       ld_size,
    input  logic [TAG_W-1:0] ld_tag,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_wdata,
    input  logic [3:0]       st_wstrb,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic             mem_req_we,
    output logic [31:0]      mem_req_addr,
    output logic [1:0]       mem_req_size,
    output logic [31:0]      mem_req_wdata,
    output logic [3:0]       mem_req_wstrb,
    input  logic             mem_resp_valid,
    input  logic [31:0]      mem_resp_rdata,
    output logic             ld_resp_valid,
    output logic [TAG_W-1:0] ld_resp_tag,
    output logic [31:0]      ld_resp_data,
    output logic             st_ack,
    output logic             spurious_resp
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic             rq_valid_q, rq_we_q;
    logic [31:0]      rq_addr_q, rq_wdata_q;
    logic [1:0]       rq_size_q;
    logic [3:0]       rq_wstrb_q;
    logic [TAG_W-1:0] rq_tag_q;
    logic [DEPTH-1:0] f_load_q, f_kill_q;
    logic [TAG_W-1:0] f_tag_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             rr_q, spur_q;
    logic             handoff, rsp_pop, can_acc, starve, ld_pick;
    logic [CW:0]      occ;

    assign handoff = rq_valid_q & mem_req_ready;
    assign rsp_pop = mem_resp_valid & (cnt_q != '0);
    // Everything already accepted (FIFO plus request register) must still fit once the new one lands.
    assign occ     = {1'b0, cnt_q} + {{CW{1'b0}}, rq_valid_q} - {{CW{1'b0}}, rsp_pop};
    assign can_acc = rst_n & (!rq_valid_q | handoff) & (occ < (CW+1)'(DEPTH));
    assign starve  = wait_q >= WW'(MAX_WAIT);
    assign ld_pick = ld_valid & !flush_valid & (starve | !st_valid | (!st_urgent & !rr_q));
    assign ld_ready = can_acc & ld_pick;
    assign st_ready = can_acc & st_valid & !ld_pick;

    assign mem_req_valid = rq_valid_q;
    assign mem_req_we    = rq_we_q;
    assign mem_req_addr  = rq_addr_q;
    assign mem_req_size  = rq_size_q;
    assign mem_req_wdata = rq_wdata_q;
    assign mem_req_wstrb = rq_wstrb_q;

    assign ld_resp_valid = rsp_pop & f_load_q[rd_q] & !f_kill_q[rd_q] & !flush_valid;
    assign ld_resp_tag   = ld_resp_valid ? f_tag_q[rd_q] : '0;
    assign ld_resp_data  = ld_resp_valid ? mem_resp_rdata : '0;
    assign st_ack        = rsp_pop & !f_load_q[rd_q];
    assign spurious_resp = spur_q;

    assign cnt_d  = cnt_q + CW'(handoff) - CW'(rsp_pop);
    assign wait_d = (ld_valid & !ld_ready) ? (starve ? wait_q : wait_q + 1'b1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq_valid_q <= 1'b0;
            rq_we_q    <= 1'b0;
            rq_addr_q  <= '0;
            rq_size_q  <= '0;
            rq_wdata_q <= '0;
            rq_wstrb_q <= '0;
            rq_tag_q   <= '0;
            f_load_q   <= '0;
            f_kill_q   <= '0;
            for (int i = 0; i < DEPTH; i++) f_tag_q[i] <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            wait_q     <= '0;
            rr_q       <= 1'b0;
            spur_q     <= 1'b0;
        end else begin
            if (ld_ready | st_ready) begin
                rq_valid_q <= 1'b1;
                rq_we_q    <= st_ready;
                rq_addr_q  <= st_ready ? st_addr : ld_addr;
                rq_size_q  <= st_ready ? 2'd2 : ld_size;
                rq_wdata_q <= st_ready ? st_wdata : '0;
                rq_wstrb_q <= st_ready ? st_wstrb : '0;
                rq_tag_q   <= st_ready ? '0 : ld_tag;
                rr_q       <= ld_ready;
            end else if (handoff | (flush_valid & rq_valid_q & !rq_we_q)) begin
                rq_valid_q <= 1'b0;
            end
            // Kill bits only matter for loads; a load handed off during a flush is already in flight.
            if (flush_valid) f_kill_q <= '1;
            if (handoff) begin
                f_load_q[wr_q] <= !rq_we_q;
                f_kill_q[wr_q] <= flush_valid;
                f_tag_q[wr_q]  <= rq_tag_q;
                wr_q           <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
            end
            if (rsp_pop) rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
            if (mem_resp_valid & (cnt_q == '0)) spur_q <= 1'b1;
            cnt_q  <= cnt_d;
            wait_q <= wait_d;
        end
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 6, meaning load tag width (ROB index).
REQ-002 SHALL have parameter DEPTH, default 4, meaning max outstanding memory transactions (power of 2).
REQ-003 SHALL have parameter MAX_WAIT, default 8, meaning load-starvation threshold in cycles.
REQ-004 SHALL have ports:
  clk  in  1  clock
  rst_n  in  1  reset, asynchronous, active-low
  flush_valid  in  1  kill all in-flight loads
  st_urgent  in  1  store queue near full; stores get priority
  ld_valid  in  1  load request
  ld_ready  out  1  load request accepted
  ld_addr  in  32  load byte address
  ld_size  in  2  0=B, 1=H, 2=W
  ld_tag  in  TAG_W  load ROB tag
  st_valid  in  1  committed-store drain request
  st_ready  out  1  store request accepted
  st_addr  in  32  store byte address
  st_wdata  in  32  store data
  st_wstrb  in  4  byte enables
  mem_req_valid  out  1  memory request
  mem_req_ready  in  1  memory accepts request
  mem_req_we  out  1  1=write
  mem_req_addr  out  32  address
  mem_req_size  out  2  size
  mem_req_wdata  out  32  write data
  mem_req_wstrb  out  4  byte enables, 0 for reads
  mem_resp_valid  in  1  in-order response, one per accepted request
  mem_resp_rdata  in  32  read data
  ld_resp_valid  out  1  load data valid, 1-cycle pulse
  ld_resp_tag  out  TAG_W  tag of returning load
  ld_resp_data  out  32  raw read data
  st_ack  out  1  store write acknowledged, 1-cycle pulse
  spurious_resp  out  1  sticky: response received with nothing outstanding

Function
REQ-005 SHALL hold a one-entry request register; mem_req_* driven only from it; latency from accept to mem_req_valid = 1 cycle.
REQ-006 SHALL accept at most one requester per cycle, only when request register empty or popping (mem_req_valid & mem_req_ready) and the outstanding FIFO has a slot, counting a same-cycle response pop.
REQ-007 SHALL hold mem_req_valid and all mem_req_* stable until mem_req_ready.
REQ-008 SHALL arbitrate priority: (1) load if its wait counter >= MAX_WAIT; (2) store if st_urgent; (3) round-robin, pointer toggled to the other requester after each grant.
REQ-009 SHALL count wait cycles: increment (saturating at MAX_WAIT) while ld_valid & !ld_ready, clear on load accept or !ld_valid.
REQ-010 SHALL push {is_load, tag, killed=0} into the outstanding FIFO when the request register hands off to memory.
REQ-011 SHALL on mem_resp_valid pop the FIFO head: load and not killed -> ld_resp_valid, tag, data same cycle; killed load -> dropped silently; store -> st_ack.
REQ-012 SHALL on flush_valid set killed on every load in FIFO, drop a load in the request register if not yet handed off, and force ld_ready=0 that cycle; stores are unaffected.
REQ-013 SHALL drop a load response arriving in the flush cycle.
REQ-014 SHALL on mem_resp_valid with empty FIFO set spurious_resp and emit no pulses.
REQ-015 SHALL wrap FIFO pointers modulo DEPTH and use a count of width clog2(DEPTH)+1.

Reset
REQ-016 SHALL on rst_n low clear request register, FIFO, count, wait counter, RR pointer (load first), and spurious_resp; all outputs 0.
REQ-017 SHALL on reset mid-transaction abandon all outstanding state without emitting responses.

Verification
REQ-018 Both valid, st_urgent=0, mem_req_ready=1 -> grants alternate L,S,L,S; each mem_req_valid 1 cycle after accept.
REQ-019 st_valid, st_urgent=1 continuously, ld_valid held -> load granted in cycle 9 (wait=8), then stores resume.
REQ-020 4 loads outstanding, no response -> ld_ready=0; response + new load same cycle -> accepted.
REQ-021 2 loads outstanding, flush_valid -> both responses dropped, ld_resp_valid stays 0; following store gets st_ack.
REQ-022 mem_req_ready=0 for 5 cycles -> mem_req_addr/wdata stable; mem_resp_valid with empty FIFO -> spurious_resp=1 until reset.
